// File: rtl/cpuex_mem_pkg.sv
// rtl/cpuex_mem_pkg.sv - shared constants, FSM encoding and access-size decode for the MEM stage
package cpuex_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam int MEM_STATE_DEFAULT = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_DONE
   } mem_fsm_t;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } acc_size_t;

   // Unknown load encodings fall back to a full word.
   function automatic acc_size_t load_size(input logic [2:0] f3);
      case (f3)
         F3_LB, F3_LBU: return SZ_BYTE;
         F3_LH, F3_LHU: return SZ_HALF;
         F3_LW:         return SZ_WORD;
         default:       return SZ_WORD;
      endcase
   endfunction

   function automatic acc_size_t store_size(input logic [1:0] f2);
      case (f2)
         F3_LB[1:0]: return SZ_BYTE;
         F3_LH[1:0]: return SZ_HALF;
         default:    return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and lane extraction/extension for loads
module mem_lane_align
   import cpuex_mem_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] ram_word,
   output logic [3:0]  byte_en,
   output logic [31:0] store_word,
   output logic [31:0] load_data,
   output logic        misaligned
);

   acc_size_t   size;
   logic [31:0] shifted;

   always_comb begin
      size       = is_store ? store_size(funct3[1:0]) : load_size(funct3);
      misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                   ((size == SZ_WORD) && (addr_lo != 2'b00));
      byte_en    = 4'b0000;
      store_word = 32'h0;
      // Replicating the low bits puts them in every lane; byte_en picks the live one.
      case (size)
         SZ_BYTE: begin
            byte_en    = 4'b0001 << addr_lo;
            store_word = {4{store_data[7:0]}};
         end
         SZ_HALF: begin
            byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
            store_word = {2{store_data[15:0]}};
         end
         default: begin
            byte_en    = 4'b1111;
            store_word = store_data;
         end
      endcase
      shifted = ram_word >> {addr_lo, 3'b000};
      case (size)
         SZ_BYTE: load_data = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
         SZ_HALF: load_data = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM pipeline stage with internal data RAM and multi-cycle loads
// MEM_BOUNDS_CHECK_EN: when defined, addresses beyond the RAM fault instead of wrapping.
module mem_stage_ctrl
   import cpuex_mem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int RD_LAT      = 1,
   parameter int MEM_STATE   = MEM_STATE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        state,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_write_data,
   input  logic              branch_in,
   input  logic [31:0]       branch_addr_in,
   input  logic              reg_write_in,
   input  logic [4:0]        write_reg_in,
   input  logic [31:0]       reg_write_data_in,
   output logic              branch_out,
   output logic [31:0]       branch_addr_out,
   output logic              reg_write_out,
   output logic [4:0]        write_reg_out,
   output logic [31:0]       reg_write_data_out,
   output logic              busy,
   output logic              misaligned
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [31:0]      ram [DEPTH_WORDS];
   mem_fsm_t         fsm_q, fsm_d;
   logic [2:0]       cnt_q;
   logic [IDX_W-1:0] idx;
   logic [2:0]       f3_q;
   logic [1:0]       addr_lo_q;
   logic [31:0]      rd_word_q;
   logic             br_q, rw_q;
   logic [31:0]      br_addr_q;
   logic [4:0]       wreg_q;

   logic             in_idle, active, is_load, oob, lane_mis, fault;
   logic             take_simple, take_load, finish_load, ram_we;
   logic [3:0]       byte_en;
   logic [31:0]      store_word, load_data;

   assign in_idle = (fsm_q == ST_IDLE);
   assign active  = in_idle && (state == 3'(MEM_STATE));
   assign is_load = mem_read && !mem_write;
   assign idx     = IDX_W'(mem_addr >> 2);

`ifdef MEM_BOUNDS_CHECK_EN
   assign oob = 64'(mem_addr) >= (64'(DEPTH_WORDS) << 2);
`else
   assign oob = 1'b0;
`endif

   assign fault = (mem_read || mem_write) && (lane_mis || oob);

   // Live request drives the aligner in IDLE; the captured load drives it while waiting.
   mem_lane_align u_align (
      .is_store   (in_idle && mem_write),
      .funct3     (in_idle ? funct3 : f3_q),
      .addr_lo    (in_idle ? mem_addr[1:0] : addr_lo_q),
      .store_data (mem_write_data),
      .ram_word   (rd_word_q),
      .byte_en    (byte_en),
      .store_word (store_word),
      .load_data  (load_data),
      .misaligned (lane_mis)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fsm_q <= ST_IDLE;
      else      fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         ST_IDLE: begin
            if (take_load)        fsm_d = ST_RD_WAIT;
            else if (take_simple) fsm_d = ST_DONE;
         end
         ST_RD_WAIT: if (finish_load) fsm_d = ST_DONE;
         ST_DONE:    fsm_d = ST_IDLE;
         default:    fsm_d = ST_IDLE;
      endcase
   end

   always_comb begin
      take_simple = 1'b0;
      take_load   = 1'b0;
      finish_load = 1'b0;
      ram_we      = 1'b0;
      case (fsm_q)
         ST_IDLE: begin
            if (active) begin
               take_load   = is_load && !fault;
               take_simple = !(is_load && !fault);
               ram_we      = rst && mem_write && !fault;
            end
         end
         ST_RD_WAIT: finish_load = (cnt_q == 3'd0);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_we && byte_en[b]) ram[idx][8*b +: 8] <= store_word[8*b +: 8];
      end
      if (take_load) rd_word_q <= ram[idx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branch_out         <= 1'b0;
         branch_addr_out    <= 32'h0;
         reg_write_out      <= 1'b0;
         write_reg_out      <= 5'h0;
         reg_write_data_out <= 32'h0;
         busy               <= 1'b0;
         misaligned         <= 1'b0;
         cnt_q              <= 3'd0;
         f3_q               <= 3'd0;
         addr_lo_q          <= 2'd0;
         br_q               <= 1'b0;
         br_addr_q          <= 32'h0;
         rw_q               <= 1'b0;
         wreg_q             <= 5'h0;
      end else begin
         misaligned <= take_simple && fault;
         if (take_simple) begin
            branch_out         <= branch_in;
            branch_addr_out    <= branch_addr_in;
            reg_write_out      <= reg_write_in && !fault;
            write_reg_out      <= write_reg_in;
            reg_write_data_out <= reg_write_data_in;
         end
         if (take_load) begin
            busy      <= 1'b1;
            cnt_q     <= 3'(RD_LAT - 1);
            f3_q      <= funct3;
            addr_lo_q <= mem_addr[1:0];
            br_q      <= branch_in;
            br_addr_q <= branch_addr_in;
            rw_q      <= reg_write_in;
            wreg_q    <= write_reg_in;
         end
         if (fsm_q == ST_RD_WAIT && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
         // Control fields are released together with the load data so WB never sees a half result.
         if (finish_load) begin
            busy               <= 1'b0;
            branch_out         <= br_q;
            branch_addr_out    <= br_addr_q;
            reg_write_out      <= rw_q;
            write_reg_out      <= wreg_q;
            reg_write_data_out <= load_data;
         end
      end
   end

endmodule
